nioshello_onchip_memory_dp: RTL and testbench

Parametrised dual-port Avalon-MM on-chip RAM, successor to the single-port on-chip memory used by the Nios II system. It exposes two independent pipelined slaves, s1 and s2, over one shared array. Both slaves support byte enables, readdatavalid and waitrequest. Beyond the single-port part it adds a configurable read latency, a clear-on-reset engine and out-of-range address detection. It sits on the Qsys interconnect between the CPU data master (s1) and a DMA or instruction master (s2).

---
 rtl/nioshello_onchip_memory_dp_pkg.sv | 19 +
 rtl/nioshello_onchip_memory_dp_ram_tdp.sv | 42 ++++
 rtl/nioshello_onchip_memory_dp.sv | 177 +++++++++++++++++
 tb/tb_nioshello_onchip_memory_dp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nioshello_onchip_memory_dp_pkg.sv
// Shared types and elaboration helpers for the dual-port on-chip memory.
package niosHello_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int BYTE_W = 8;

  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic bit latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/nioshello_onchip_memory_dp_ram_tdp.sv
// True-dual-port byte-enabled array with one registered read per port.
// A read returns pre-write data when the other port writes the same word.
module niosHello_ram_tdp
  import niosHello_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 30720,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              a_we_i,
  input  logic              a_re_i,
  input  logic [BE_W-1:0]   a_be_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_we_i,
  input  logic              b_re_i,
  input  logic [BE_W-1:0]   b_be_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (a_we_i && a_be_i[i]) mem_q[a_addr_i][i*BYTE_W +: BYTE_W] <= a_wdata_i[i*BYTE_W +: BYTE_W];
      if (b_we_i && b_be_i[i]) mem_q[b_addr_i][i*BYTE_W +: BYTE_W] <= b_wdata_i[i*BYTE_W +: BYTE_W];
    end
    if (a_re_i) a_rdata_q <= mem_q[a_addr_i];
    if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/nioshello_onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM: two pipelined slaves over one array,
// with a post-reset clear engine and sticky out-of-range detection.
module nioshello_onchip_memory_dp
  import niosHello_mem_pkg::*;
#(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 15,
  parameter int                DEPTH          = 30720,
  parameter int                READ_LATENCY   = 1,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_waitrequest,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_read,
  input  logic                  s2_write,
  input  logic [DATA_W/8-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0]     s2_writedata,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_waitrequest,
  output logic                  busy,
  output logic                  range_err
);

  localparam int                BEW      = be_width(DATA_W);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  if (!latency_legal(READ_LATENCY) || (DATA_W % 8) != 0 || DEPTH > 2**ADDR_W) begin : g_bad_param
    $error("nioshello_onchip_memory_dp: illegal READ_LATENCY, DATA_W or DEPTH");
  end

  mem_state_e        state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              range_err_q;
  logic              wait_req;

  logic [ADDR_W-1:0] p_addr [2];
  logic [DATA_W-1:0] p_wdata [2];
  logic [BEW-1:0]    p_be [2];
  logic [DATA_W-1:0] ram_rdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic [1:0]        p_cs, p_rd, p_wr, req, oor, rd_acc, wr_acc, rdv;

  assign p_addr[0]  = s1_address;
  assign p_addr[1]  = s2_address;
  assign p_wdata[0] = s1_writedata;
  assign p_wdata[1] = s2_writedata;
  assign p_be[0]    = s1_byteenable;
  assign p_be[1]    = s2_byteenable;
  assign p_cs       = {s2_chipselect, s1_chipselect};
  assign p_rd       = {s2_read, s1_read};
  assign p_wr       = {s2_write, s1_write};

  assign busy           = (state_q == CLEAR);
  assign wait_req       = ~reset_n | busy | ~clken;
  assign s1_waitrequest = wait_req;
  assign s2_waitrequest = wait_req;
  assign range_err      = range_err_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              v1_q;
    logic              mask_q;  // forces zero data after reset and for out-of-range reads
    logic [DATA_W-1:0] d1;

    assign req[gi]    = p_cs[gi] & (p_rd[gi] | p_wr[gi]) & ~wait_req;
    assign oor[gi]    = {1'b0, p_addr[gi]} >= DEPTH_C;
    assign rd_acc[gi] = req[gi] & ~p_wr[gi];
    assign wr_acc[gi] = req[gi] & p_wr[gi] & ~oor[gi];
    assign d1         = mask_q ? '0 : ram_rdata[gi];

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v1_q   <= 1'b0;
        mask_q <= 1'b1;
      end else if (clken) begin
        v1_q <= rd_acc[gi];
        if (rd_acc[gi]) mask_q <= oor[gi];
      end
    end

    if (READ_LATENCY == 2) begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
        end else if (clken) begin
          v2_q <= v1_q;
          if (v1_q) d2_q <= d1;
        end
      end
      assign rdv[gi]   = v2_q;
      assign rdata[gi] = d2_q;
    end else begin : g_lat1
      assign rdv[gi]   = v1_q;
      assign rdata[gi] = d1;
    end
  end

  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = rdv[0];
  assign s2_readdatavalid = rdv[1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr_q  <= '0;
      range_err_q <= 1'b0;
    end else begin
      if (state_q == CLEAR && clken) begin
        if (clr_addr_q == CLR_LAST) state_q <= READY;
        else clr_addr_q <= clr_addr_q + 1'b1;
      end
      if (|(req & oor)) range_err_q <= 1'b1;
    end
  end

  // Port A carries the clear engine while busy; s1 wins byte collisions with s2.
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [BEW-1:0]    a_be, b_be;

  always_comb begin
    if (busy) begin
      a_we    = clken & reset_n;
      a_addr  = clr_addr_q;
      a_wdata = CLEAR_VALUE;
      a_be    = '1;
    end else begin
      a_we    = wr_acc[0];
      a_addr  = p_addr[0];
      a_wdata = p_wdata[0];
      a_be    = p_be[0];
    end
    b_be = p_be[1];
    if (a_we && a_addr == p_addr[1]) b_be = p_be[1] & ~a_be;
  end

  niosHello_ram_tdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BE_W   (BEW)
  ) u_ram (
    .clk       (clk),
    .a_we_i    (a_we),
    .a_re_i    (rd_acc[0]),
    .a_be_i    (a_be),
    .a_addr_i  (a_addr),
    .a_wdata_i (a_wdata),
    .a_rdata_o (ram_rdata[0]),
    .b_we_i    (wr_acc[1]),
    .b_re_i    (rd_acc[1]),
    .b_be_i    (b_be),
    .b_addr_i  (p_addr[1]),
    .b_wdata_i (p_wdata[1]),
    .b_rdata_o (ram_rdata[1])
  );

endmodule

// File: tb/tb_nioshello_onchip_memory_dp.sv
// Bench for the dual-port on-chip memory: vector table plus hand sequences,
// with a per-port scoreboard checking data and arrival cycle of every read.
module tb_nioshello_onchip_memory_dp;

  localparam int          DW  = 32;
  localparam int          AW  = 5;
  localparam int          DEP = 16;
  localparam int          LAT = 2;
  localparam logic [31:0] CV  = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          reset_n, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]    s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;
  logic          busy, range_err;

  nioshello_onchip_memory_dp #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_LATENCY(LAT),
    .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .busy(busy), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int busy_total = 0;
  always @(negedge clk) if (busy) busy_total <= busy_total + 1;

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t q1[$];
  exp_t q2[$];
  int   checks = 0;
  int   failures = 0;
  int   stall = 0;

  typedef struct {
    int port; bit rd; bit wr; int addr; logic [31:0] wdata; logic [3:0] be; logic [31:0] exp;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic drive(input int p, input bit r, input bit w, input int a,
                       input logic [31:0] d, input logic [3:0] b, input logic [31:0] e);
    exp_t x;
    x.cyc  = cyc + LAT + stall;
    x.data = e;
    if (p == 0) begin
      s1_chipselect = 1; s1_read = r; s1_write = w;
      s1_address = AW'(a); s1_writedata = d; s1_byteenable = b;
      if (r && !w) q1.push_back(x);
    end else begin
      s2_chipselect = 1; s2_read = r; s2_write = w;
      s2_address = AW'(a); s2_writedata = d; s2_byteenable = b;
      if (r && !w) q2.push_back(x);
    end
  endtask

  task automatic sb_pop(input int p, input logic [31:0] act);
    exp_t e;
    if ((p == 0 && q1.size() == 0) || (p == 1 && q2.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL s%0d_unexpected_valid: got data %0h, required no valid", p + 1, act);
    end else begin
      if (p == 0) e = q1.pop_front();
      else        e = q2.pop_front();
      $display("s%0d read cyc=%0d data=%0h expect_cyc=%0d expect_data=%0h", p + 1, cyc, act, e.cyc, e.data);
      chk($sformatf("s%0d_rd_cycle", p + 1), cyc, e.cyc);
      chk($sformatf("s%0d_rd_data", p + 1), act, e.data);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clear_done_timeout", 32'(busy), 0);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() + q2.size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("sb_drain", q1.size() + q2.size(), 0);
  endtask

  initial begin
    int base;
    vt[0]  = '{0, 0, 1, 3,  32'h11223344, 4'hF, 32'h0};
    vt[1]  = '{0, 0, 1, 3,  32'hAABBCCDD, 4'h5, 32'h0};
    vt[2]  = '{1, 1, 0, 3,  32'h0,        4'h0, 32'h11BB33DD};
    vt[3]  = '{0, 0, 1, 3,  32'h00000000, 4'h0, 32'h0};
    vt[4]  = '{0, 1, 0, 3,  32'h0,        4'h0, 32'h11BB33DD};
    vt[5]  = '{1, 0, 1, 9,  32'hCAFEF00D, 4'hC, 32'h0};
    vt[6]  = '{0, 1, 0, 9,  32'h0,        4'h0, 32'hCAFEA5A5};
    vt[7]  = '{0, 1, 1, 9,  32'h12345678, 4'hF, 32'h0};
    vt[8]  = '{1, 1, 0, 9,  32'h0,        4'h0, 32'h12345678};
    vt[9]  = '{1, 0, 1, 10, 32'h0000BEEF, 4'h3, 32'h0};
    vt[10] = '{1, 1, 0, 10, 32'h0,        4'h0, 32'hA5A5BEEF};
    vt[11] = '{0, 1, 0, 0,  32'h0,        4'h0, CV};
    vt[12] = '{1, 1, 0, 15, 32'h0,        4'h0, CV};

    reset_n = 0; clken = 1;
    s1_address = '0; s2_address = '0; s1_byteenable = '0; s2_byteenable = '0;
    s1_writedata = '0; s2_writedata = '0;
    idle();

    fork
      forever begin
        @(negedge clk);
        if (s1_readdatavalid) sb_pop(0, s1_readdata);
        if (s2_readdatavalid) sb_pop(1, s2_readdata);
      end
    join_none

    // Reset state
    tick(); tick();
    @(negedge clk);
    chk("rst_s1_readdata", s1_readdata, 0);
    chk("rst_s1_valid", 32'(s1_readdatavalid), 0);
    chk("rst_s2_valid", 32'(s2_readdatavalid), 0);
    chk("rst_s1_wait", 32'(s1_waitrequest), 1);
    chk("rst_s2_wait", 32'(s2_waitrequest), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_range_err", 32'(range_err), 0);

    // Clear fill and its duration
    tick();
    reset_n = 1;
    base = busy_total;
    wait_ready();
    chk("clear_busy_cycles", busy_total - base, DEP);
    chk("ready_s1_wait", 32'(s1_waitrequest), 0);
    chk("ready_s2_wait", 32'(s2_waitrequest), 0);
    for (int a = 0; a < DEP; a++) begin
      drive(0, 1, 0, a, 0, 0, CV);
      tick();
    end
    idle();

    // Table of single-port accesses, one per cycle
    for (int i = 0; i < 13; i++) begin
      idle();
      drive(vt[i].port, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].exp);
      tick();
    end
    idle();
    drain();

    // Same-cycle collision and cross-port old-data reads
    drive(0, 0, 1, 5, 32'h000000FF, 4'h1, 0);
    drive(1, 0, 1, 5, 32'hFFFFFF00, 4'hF, 0);
    tick(); idle();
    drive(0, 1, 0, 5, 0, 0, 32'hFFFFFFFF);
    tick(); idle();
    drive(0, 0, 1, 5, 32'h12345678, 4'hF, 0);
    drive(1, 1, 0, 5, 0, 0, 32'hFFFFFFFF);
    tick(); idle();
    drive(1, 1, 0, 5, 0, 0, 32'h12345678);
    tick(); idle();
    drive(1, 0, 1, 6, 32'h01020304, 4'hF, 0);
    drive(0, 1, 0, 6, 0, 0, CV);
    tick(); idle();
    drive(0, 1, 0, 6, 0, 0, 32'h01020304);
    tick(); idle();
    drain();

    // Out-of-range accesses
    chk("range_err_before", 32'(range_err), 0);
    drive(0, 0, 1, 20, 32'hDEADBEEF, 4'hF, 0);
    tick(); idle();
    drive(0, 1, 0, 20, 0, 0, 0);
    tick(); idle();
    drive(0, 1, 0, 4, 0, 0, CV);
    drive(1, 1, 0, 17, 0, 0, 0);
    tick(); idle();
    drain();
    tick(); tick();
    chk("range_err_sticky", 32'(range_err), 1);
    chk("s1_readdata_held", s1_readdata, CV);
    chk("s1_valid_idle", 32'(s1_readdatavalid), 0);

    // clken low freezes the read pipeline
    stall = 2;
    drive(0, 1, 0, 9, 0, 0, 32'h12345678);
    stall = 0;
    tick(); idle();
    clken = 0;
    tick(); tick();
    clken = 1;
    drain();

    // Reset clears outputs and range_err; clken low stretches the clear
    reset_n = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst2_s1_readdata", s1_readdata, 0);
    chk("rst2_range_err", 32'(range_err), 0);
    chk("rst2_busy", 32'(busy), 1);
    tick();
    reset_n = 1;
    base = busy_total;
    repeat (4) tick();
    clken = 0;
    repeat (3) tick();
    clken = 1;
    wait_ready();
    chk("clken_busy_cycles", busy_total - base, DEP + 3);

    // Reset pulse mid-clear restarts the full fill
    reset_n = 0;
    tick();
    reset_n = 1;
    repeat (8) tick();
    chk("midclear_busy", 32'(busy), 1);
    reset_n = 0;
    tick();
    reset_n = 1;
    base = busy_total;
    wait_ready();
    chk("restart_busy_cycles", busy_total - base, DEP);
    drive(0, 1, 0, 5, 0, 0, CV);
    drive(1, 1, 0, 9, 0, 0, CV);
    tick(); idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
